// File: rtl/axi_rd_sched_pkg.sv
// Shared definitions for the read-side scheduler: head FSM states, AXI response
// codes and the outstanding-entry layout {deny, id, user, len}.
package axi_rd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PASS_WAIT = 2'd1,
        ST_DROP_REQ  = 2'd2,
        ST_DROP_WAIT = 2'd3
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned ENT_LEN_W = 8;

    function automatic int unsigned ent_width(input int unsigned id_wid,
                                              input int unsigned user_wid);
        return 1 + id_wid + user_wid + ENT_LEN_W;
    endfunction

endpackage

// File: rtl/axi_rd_ot_fifo.sv
// Outstanding-burst FIFO with show-ahead head, full/empty flags and async reset.
module axi_rd_ot_fifo #(
    parameter int unsigned DW    = 19,
    parameter int unsigned DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axi_rd_sched.sv
// Read-side scheduler: routes allowed AR bursts to memory, queues denied ones and
// replays them as SLVERR drops in AR order on the shared in-order R datapath.
module axi_rd_sched
    import axi_rd_sched_pkg::*;
#(
    parameter int unsigned ID_WID   = 8,
    parameter int unsigned USER_WID = 2,
    parameter int unsigned ADDR_WID = 32,
    parameter int unsigned OT_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ID_WID-1:0]   in_arid,
    input  logic [ADDR_WID-1:0] in_araddr,
    input  logic [7:0]          in_arlen,
    input  logic [2:0]          in_arsize,
    input  logic [USER_WID-1:0] in_aruser,
    input  logic                in_arvalid,
    input  logic                in_ar_deny,
    output logic                out_arready,
    output logic [ID_WID-1:0]   out_m_arid,
    output logic [ADDR_WID-1:0] out_m_araddr,
    output logic [7:0]          out_m_arlen,
    output logic [2:0]          out_m_arsize,
    output logic [USER_WID-1:0] out_m_aruser,
    output logic                out_m_arvalid,
    input  logic                in_m_arready,
    input  logic                in_rlast_hs,
    output logic                out_drop,
    output logic [ID_WID-1:0]   out_drop_arid,
    output logic [USER_WID-1:0] out_drop_aruser,
    output logic [7:0]          out_drop_len,
    input  logic                in_drop_done,
    output logic [15:0]         out_drop_cnt,
    output logic                out_err
);

    localparam int unsigned EW = ent_width(ID_WID, USER_WID);

    rd_state_e             state;
    logic                  q_full;
    logic                  q_empty;
    logic                  q_push;
    logic                  q_pop;
    logic [EW-1:0]         q_head;
    logic                  head_deny;
    logic [ID_WID-1:0]     head_id;
    logic [USER_WID-1:0]   head_user;
    logic [7:0]            head_len;
    logic                  len_max;
    logic                  deny_bad;
    logic                  stray_rlast;
    logic                  stray_done;

    assign len_max       = (in_arlen == 8'hFF);
    assign deny_bad      = in_arvalid & in_ar_deny & len_max;
    assign out_arready   = ~q_full & (in_ar_deny ? ~len_max : in_m_arready);
    assign out_m_arvalid = in_arvalid & ~in_ar_deny & ~q_full;
    assign q_push        = in_arvalid & out_arready;

    assign out_m_arid    = in_arid;
    assign out_m_araddr  = in_araddr;
    assign out_m_arlen   = in_arlen;
    assign out_m_arsize  = in_arsize;
    assign out_m_aruser  = in_aruser;

    assign q_pop       = ((state == ST_PASS_WAIT) & in_rlast_hs) |
                         ((state == ST_DROP_WAIT) & in_drop_done);
    assign stray_rlast = in_rlast_hs & (state != ST_PASS_WAIT);
    assign stray_done  = in_drop_done & (state != ST_DROP_WAIT);

    assign head_deny = q_head[EW-1];
    assign head_id   = q_head[EW-2 -: ID_WID];
    assign head_user = q_head[ENT_LEN_W +: USER_WID];
    assign head_len  = q_head[ENT_LEN_W-1:0];

    axi_rd_ot_fifo #(
        .DW    (EW),
        .DEPTH (OT_DEPTH)
    ) u_ot_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .push_data ({in_ar_deny, in_arid, in_aruser, in_arlen}),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            out_drop        <= 1'b0;
            out_drop_arid   <= '0;
            out_drop_aruser <= '0;
            out_drop_len    <= '0;
            out_drop_cnt    <= '0;
            out_err         <= 1'b0;
        end else begin
            out_err <= out_err | deny_bad | stray_rlast | stray_done;
            case (state)
                ST_IDLE: begin
                    if (!q_empty) begin
                        // Drop outputs are loaded on entry so they are already valid
                        // during the single DROP_REQ cycle.
                        if (head_deny) begin
                            state           <= ST_DROP_REQ;
                            out_drop        <= 1'b1;
                            out_drop_arid   <= head_id;
                            out_drop_aruser <= head_user;
                            out_drop_len    <= head_len + 8'd1;
                        end else begin
                            state <= ST_PASS_WAIT;
                        end
                    end
                end
                ST_PASS_WAIT: begin
                    if (in_rlast_hs) state <= ST_IDLE;
                end
                ST_DROP_REQ: begin
                    out_drop <= 1'b0;
                    state    <= ST_DROP_WAIT;
                end
                ST_DROP_WAIT: begin
                    if (in_drop_done) begin
                        state <= ST_IDLE;
                        if (out_drop_cnt != '1) out_drop_cnt <= out_drop_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
